// File: rtl/boot_loader.sv
// boot_loader: receives a big-endian byte count and a program image over UART,
// packs it into little-endian 32-bit words written to instruction memory from
// word 0, acknowledges the host, then releases the CPU.

// One byte lane of the word assembly buffer. Clear has priority so the lane
// that completes a word starts the next word empty.
module boot_loader_lane (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wr,
  input  logic       i_clr,
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  logic [7:0] r_byte;

  // Hold one received byte until its word is written.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      r_byte <= 8'h00;
    else if (i_clr) r_byte <= 8'h00;
    else if (i_wr)  r_byte <= i_byte;
  end

  assign o_byte = r_byte;
endmodule

module boot_loader #(
  parameter int          ADDR_W    = 10,
  parameter int          MAX_BYTES = 4096,
  parameter logic [7:0]  ACK_OK    = 8'hAA,
  parameter logic [7:0]  ACK_ERR   = 8'hEE
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  input  logic              i_tx_busy,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_start,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_cpu_run,
  output logic              o_load_err
);
  localparam int NUM_LANES = 4;

  typedef enum logic [2:0] {S_SIZE, S_DATA, S_ACK, S_RUN, S_ERR} state_t;

  state_t                      r_state, w_state_nx;
  logic [31:0]                 r_size;
  logic [1:0]                  r_szcnt;
  logic [31:0]                 r_cnt;
  logic                        r_done;
  logic                        r_we;
  logic [ADDR_W-1:0]           r_addr;
  logic [31:0]                 r_wdata;
  logic                        r_err_sent;

  logic [31:0]                 w_size_nx;
  logic                        w_acc, w_final, w_complete;
  logic                        w_tx_start;
  logic [7:0]                  w_tx_data;
  logic [NUM_LANES-1:0][7:0]   w_buf, w_word;

  assign w_size_nx  = {r_size[23:0], i_rx_data};
  // Bytes past the final one are ignored while the last word drains.
  assign w_acc      = i_rx_valid && (r_state == S_DATA) && !r_done;
  assign w_final    = w_acc && ((r_cnt + 32'd1) == r_size);
  assign w_complete = w_acc && ((r_cnt[1:0] == 2'd3) || w_final);

  // Byte lanes; the word presented for writing merges in the incoming byte so
  // the completing byte needs no extra cycle.
  genvar l;
  generate
    for (l = 0; l < NUM_LANES; l++) begin : g_lane
      logic w_sel;
      assign w_sel = w_acc && (r_cnt[1:0] == 2'(l));
      boot_loader_lane u_lane (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_wr   (w_sel),
        .i_clr  (w_complete),
        .i_byte (i_rx_data),
        .o_byte (w_buf[l])
      );
      assign w_word[l] = w_sel ? i_rx_data : w_buf[l];
    end
  endgenerate

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_SIZE;
    else       r_state <= w_state_nx;
  end

  // Next state and transmit request; tx_start is gated by tx_busy directly so
  // it can never overlap a busy transmitter.
  always_comb begin
    w_state_nx = r_state;
    w_tx_start = 1'b0;
    w_tx_data  = 8'h00;
    case (r_state)
      S_SIZE: begin
        if (i_rx_valid && (r_szcnt == 2'd3)) begin
          if (w_size_nx > 32'(MAX_BYTES)) w_state_nx = S_ERR;
          else if (w_size_nx == 32'd0)    w_state_nx = S_ACK;
          else                            w_state_nx = S_DATA;
        end
      end
      S_DATA: begin
        // Leave only after the final write pulse has been presented.
        if (r_we && r_done) w_state_nx = S_ACK;
      end
      S_ACK: begin
        w_tx_data = ACK_OK;
        if (!i_tx_busy) begin
          w_tx_start = 1'b1;
          w_state_nx = S_RUN;
        end
      end
      S_RUN: begin
        w_tx_data = ACK_OK;
      end
      S_ERR: begin
        w_tx_data = ACK_ERR;
        if (!i_tx_busy && !r_err_sent) w_tx_start = 1'b1;
      end
      default: w_state_nx = S_SIZE;
    endcase
  end

  // Size shifter, byte counter and registered instruction-memory write port.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_size     <= '0;
      r_szcnt    <= '0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_err_sent <= 1'b0;
    end else begin
      if ((r_state == S_SIZE) && i_rx_valid) begin
        r_size  <= w_size_nx;
        r_szcnt <= r_szcnt + 2'd1;
      end
      r_we <= w_complete;
      if (w_complete) r_wdata <= w_word;
      if (r_we)       r_addr  <= r_addr + 1'b1;
      if (w_acc)      r_cnt   <= r_cnt + 32'd1;
      if (w_final)    r_done  <= 1'b1;
      if (w_tx_start && (r_state == S_ERR)) r_err_sent <= 1'b1;
    end
  end

  assign o_tx_start   = w_tx_start;
  assign o_tx_data    = w_tx_data;
  assign o_imem_we    = r_we;
  assign o_imem_addr  = r_addr;
  assign o_imem_wdata = r_wdata;
  assign o_cpu_run    = (r_state == S_RUN);
  assign o_load_err   = (r_state == S_ERR);
endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Sequences the program-load phase between the UART receiver, the instruction memory write port and the CPU core.
- After reset, receives a 4-byte big-endian byte count and then that many program bytes over UART.
- Packs the program bytes into 32-bit little-endian words and writes them to consecutive instruction-memory words starting at word 0.
- When loading finishes, sends an acknowledge byte to the host and releases the CPU to run.

Parameters:
- ADDR_W, 10, instruction-memory word address width.
- MAX_BYTES, 4096, largest accepted program size in bytes; must be at most 4*2^ADDR_W.
- ACK_OK, 8'hAA, byte transmitted when a load completes.
- ACK_ERR, 8'hEE, byte transmitted when the size is rejected.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- tx_busy  in  1  UART transmitter busy.
- tx_data  out  8  byte to transmit.
- tx_start  out  1  one-cycle transmit request.
- imem_we  out  1  instruction-memory write enable.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  write data.
- cpu_run  out  1  high while the core may execute; low holds the core in reset.
- load_err  out  1  high once the size is rejected.

Behaviour:
- Reset values: all outputs 0; state SIZE; byte counter, word address and shift register cleared.
- Reset asserted mid-load aborts immediately; the next load restarts from SIZE.

States:
- SIZE
  - Each rx_valid shifts rx_data into size, MSB first.
  - On the 4th byte:
    - size > MAX_BYTES -> ERR.
    - size == 0 -> ACK.
    - otherwise -> DATA.
- DATA
  - Each rx_valid places its byte into lane (cnt mod 4) of the word buffer, so byte 0 lands in bits [7:0].
  - cnt increments on every byte.
  - A word is written when its 4th byte arrives, or when the final byte (cnt+1 == size) arrives.
  - Unfilled lanes of a partial final word are written as zero.
  - Write timing: registered. imem_we is high for exactly one cycle, the cycle after the completing byte.
  - imem_addr / imem_wdata are held valid during that cycle; imem_addr then increments.
  - After the final write -> ACK.
- ACK
  - Wait for tx_busy == 0, then pulse tx_start for one cycle with tx_data = ACK_OK.
  - Then -> RUN.
- RUN
  - cpu_run = 1, asserted the cycle after tx_start.
  - rx_valid is ignored.
  - Terminal until rst.
- ERR
  - load_err = 1.
  - Wait for tx_busy == 0, send ACK_ERR once.
  - Then remain in ERR with cpu_run = 0, ignoring rx_valid.

Boundary and timing rules:
- rx_valid in the same cycle as a pending imem_we is accepted normally; one byte per cycle is supported in DATA without loss.
- tx_start is never asserted while tx_busy = 1; tx_data is stable from tx_start until tx_busy falls.
- size exactly MAX_BYTES is accepted.
- The byte counter is 32 bits; words are written only while the address is below 2^ADDR_W (guaranteed by the MAX_BYTES check).
- imem_we is never asserted outside DATA, or in the cycle immediately after the transition out of DATA.

Test Plan:
- Size 00 00 00 08, bytes 13 05 10 00 93 05 20 00 -> two writes:
  - addr0 = 32'h00100513;
  - addr1 = 32'h00200593;
  - then tx_start with tx_data = AA;
  - cpu_run = 1 one cycle after tx_start.
- Size 6, bytes 01 02 03 04 05 06 -> addr0 = 32'h04030201, addr1 = 32'h00000605 (zero pad); exactly 2 writes, then ACK and RUN.
- Size 0 -> no imem_we; AA sent; cpu_run = 1.
- Size MAX_BYTES+1 (00 00 10 01) -> load_err = 1; EE sent once; cpu_run stays 0; later rx bytes produce no writes.
- tx_busy held high for 50 cycles at the end of load -> tx_start is delayed until tx_busy falls, and cpu_run stays 0 until then.
- rst pulsed after 3 of 8 data bytes, then a full reload of size 4, bytes AA BB CC DD -> single write addr0 = 32'hDDCCBBAA, followed by normal ACK and RUN.
